// File: rtl/de0_nano_sysid_checker.sv
// -----------------------------------------------------------------------------
// de0_nano_sysid_checker
//
// Purpose: on a one-cycle start request, reads the two words of a system-ID
// peripheral over Avalon-MM (word 0 = system ID, word 1 = build timestamp),
// captures them, and reports whether both match the expected values. A
// per-read stall counter aborts the check if the slave holds waitrequest too
// long.
//
// Ports:
//   clock            single clock, rising edge
//   reset_n          asynchronous active-low reset
//   start            one-cycle request to run a check (ignored while busy)
//   avm_address      Avalon-MM word address (registered)
//   avm_read         Avalon-MM read strobe (registered)
//   avm_waitrequest  slave stall
//   avm_readdata     slave read data (valid READ_LATENCY cycles after accept)
//   busy             high while a check is in progress
//   done             one-cycle pulse when a check completes
//   pass             result of the last check
//   timeout_err      the last check aborted on a stall
//   id_value         captured word 0
//   ts_value         captured word 1
// -----------------------------------------------------------------------------
module de0_nano_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1380075566,
  parameter int          READ_LATENCY = 0,
  parameter int          TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    FINISH = 3'd5
  } state_t;

  // Latency counter preload: the capture happens on the last LAT cycle, so
  // the counter starts at READ_LATENCY-1 and captures when it reaches zero.
  localparam int          LAT_INIT_I = (READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0;
  localparam logic [1:0]  LAT_INIT   = LAT_INIT_I[1:0];
  localparam logic [15:0] TIMEOUT_C  = TIMEOUT[15:0];

  state_t      state_q,       state_d;
  logic        avm_read_q,    avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q,        busy_d;
  logic        done_q,        done_d;
  logic        pass_q,        pass_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] id_value_q,    id_value_d;
  logic [31:0] ts_value_q,    ts_value_d;
  logic [15:0] stall_cnt_q,   stall_cnt_d;
  logic [1:0]  lat_cnt_q,     lat_cnt_d;
  logic [15:0] stall_inc_s;

  // Both captured words must match their expected values for a pass.
  function automatic logic sysid_match(input logic [31:0] id, input logic [31:0] ts);
    return (id == EXPECTED_ID) && (ts == EXPECTED_TS);
  endfunction

  // Next-state and next-output logic for the check sequencer.
  always_comb begin
    state_d       = state_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    timeout_err_d = timeout_err_q;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    stall_cnt_d   = stall_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    stall_inc_s   = stall_cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RD_ID;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          busy_d        = 1'b1;
          pass_d        = 1'b0;
          timeout_err_d = 1'b0;
          stall_cnt_d   = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end

      RD_ID: begin
        // Acceptance is tested before the timeout, so a read accepted on the
        // TIMEOUT-th cycle still counts.
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            id_value_d    = avm_readdata;
            state_d       = RD_TS;
            avm_read_d    = 1'b1;
            avm_address_d = 1'b1;
            stall_cnt_d   = 16'd0;
          end else begin
            state_d    = LAT_ID;
            avm_read_d = 1'b0;
            lat_cnt_d  = LAT_INIT;
          end
        end else if (stall_inc_s == TIMEOUT_C) begin
          stall_cnt_d   = stall_inc_s;
          avm_read_d    = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = FINISH;
        end else begin
          stall_cnt_d = stall_inc_s;
        end
      end

      LAT_ID: begin
        if (lat_cnt_q == 2'd0) begin
          id_value_d    = avm_readdata;
          state_d       = RD_TS;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b1;
          stall_cnt_d   = 16'd0;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end

      RD_TS: begin
        if (!avm_waitrequest) begin
          avm_read_d = 1'b0;
          if (READ_LATENCY == 0) begin
            ts_value_d = avm_readdata;
            state_d    = FINISH;
          end else begin
            state_d   = LAT_TS;
            lat_cnt_d = LAT_INIT;
          end
        end else if (stall_inc_s == TIMEOUT_C) begin
          stall_cnt_d   = stall_inc_s;
          avm_read_d    = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = FINISH;
        end else begin
          stall_cnt_d = stall_inc_s;
        end
      end

      LAT_TS: begin
        if (lat_cnt_q == 2'd0) begin
          ts_value_d = avm_readdata;
          state_d    = FINISH;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end

      FINISH: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        avm_read_d = 1'b0;
      end

      default: begin
        state_d    = IDLE;
        avm_read_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase

    // done and pass are registered on the edge that enters FINISH, using the
    // words as they are being captured on that same edge, so both are
    // visible throughout the FINISH cycle.
    if ((state_d == FINISH) && (state_q != FINISH)) begin
      done_d = 1'b1;
      pass_d = !timeout_err_d && sysid_match(id_value_d, ts_value_d);
    end else begin
      done_d = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      id_value_q    <= 32'd0;
      ts_value_q    <= 32'd0;
      stall_cnt_q   <= 16'd0;
      lat_cnt_q     <= 2'd0;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_err_q <= timeout_err_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      stall_cnt_q   <= stall_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout_err = timeout_err_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_de0_nano_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_de0_nano_sysid_checker
//
// Purpose: directed bench for de0_nano_sysid_checker. Three instances cover
// the default configuration (u0), a short stall timeout (u1, TIMEOUT=4) and
// a pipelined slave (u2, READ_LATENCY=2). Each instance has a small slave
// model; expected values are written down by hand.
//
// Cycle numbering inside a run: start is raised just after a falling edge,
// cycle 1 is the first cycle after the edge that samples it. A zero-wait
// check shows done in cycle 3; every stall cycle and every latency cycle
// adds one cycle per read.
// -----------------------------------------------------------------------------
module tb_de0_nano_sysid_checker;

  localparam logic [31:0] TS_GOOD  = 32'd1380075566;
  localparam logic [31:0] TS_BAD   = 32'd1380075567;
  localparam logic [31:0] ID_LAT   = 32'hCAFE_0001;
  localparam logic [31:0] GARBAGE  = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

  logic        ad0, rd0, wr0, busy0, done0, pass0, to0;
  logic [31:0] rdata0, id0, ts0;
  logic        ad1, rd1, wr1, busy1, done1, pass1, to1;
  logic [31:0] rdata1, id1, ts1;
  logic        ad2, rd2, wr2, busy2, done2, pass2, to2;
  logic [31:0] rdata2, id2, ts2;

  int checks = 0;
  int errors = 0;

  // Slave knobs: stall cycles per read and returned words.
  int          stall_n0 = 0, stall_n1 = 0;
  int          wcnt0, wcnt1;
  logic [31:0] ts_word0 = TS_GOOD;

  // Latency-slave pipeline.
  logic p1_v, p1_a, p2_v, p2_a;

  // Per-run traces of the selected instance.
  int   sel = 0;
  logic rd_m, ad_m, busy_m, done_m;
  logic rd_tr [0:20];
  logic ad_tr [0:20];
  logic busy_tr [0:20];
  int   first_done, done_cnt;

  always #5 clock = ~clock;

  de0_nano_sysid_checker u0 (
    .clock(clock), .reset_n(reset_n), .start(start0),
    .avm_address(ad0), .avm_read(rd0), .avm_waitrequest(wr0), .avm_readdata(rdata0),
    .busy(busy0), .done(done0), .pass(pass0), .timeout_err(to0),
    .id_value(id0), .ts_value(ts0));

  de0_nano_sysid_checker #(.TIMEOUT(4)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start1),
    .avm_address(ad1), .avm_read(rd1), .avm_waitrequest(wr1), .avm_readdata(rdata1),
    .busy(busy1), .done(done1), .pass(pass1), .timeout_err(to1),
    .id_value(id1), .ts_value(ts1));

  de0_nano_sysid_checker #(.READ_LATENCY(2), .EXPECTED_ID(ID_LAT)) u2 (
    .clock(clock), .reset_n(reset_n), .start(start2),
    .avm_address(ad2), .avm_read(rd2), .avm_waitrequest(wr2), .avm_readdata(rdata2),
    .busy(busy2), .done(done2), .pass(pass2), .timeout_err(to2),
    .id_value(id2), .ts_value(ts2));

  // Stalling slaves for u0/u1: waitrequest high for the first stall_n cycles
  // of every read, zero-latency data.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wcnt0 <= 0;
      wcnt1 <= 0;
    end else begin
      wcnt0 <= (rd0 && wr0) ? wcnt0 + 1 : 0;
      wcnt1 <= (rd1 && wr1) ? wcnt1 + 1 : 0;
    end
  end
  assign wr0    = rd0 && (wcnt0 < stall_n0);
  assign wr1    = rd1 && (wcnt1 < stall_n1);
  assign rdata0 = ad0 ? ts_word0 : 32'd0;
  assign rdata1 = ad1 ? TS_GOOD : 32'd0;

  // Pipelined slave for u2: data valid exactly two cycles after acceptance,
  // garbage otherwise.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1_v <= 1'b0; p1_a <= 1'b0; p2_v <= 1'b0; p2_a <= 1'b0;
    end else begin
      p1_v <= rd2 && !wr2;
      p1_a <= ad2;
      p2_v <= p1_v;
      p2_a <= p1_a;
    end
  end
  assign wr2    = 1'b0;
  assign rdata2 = p2_v ? (p2_a ? TS_GOOD : ID_LAT) : GARBAGE;

  assign rd_m   = (sel == 0) ? rd0   : (sel == 1) ? rd1   : rd2;
  assign ad_m   = (sel == 0) ? ad0   : (sel == 1) ? ad1   : ad2;
  assign busy_m = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign done_m = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Pulse start on one instance and trace it for a fixed 20-cycle window;
  // optionally pulse start again at cycle restart_at.
  task automatic run(input int which, input int restart_at);
    sel = which;
    first_done = 0;
    done_cnt = 0;
    set_start(which, 1'b1);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      rd_tr[n]   = rd_m;
      ad_tr[n]   = ad_m;
      busy_tr[n] = busy_m;
      if (done_m) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
      end
      set_start(which, n == restart_at);
    end
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clock);
    check1("rst_busy", busy0, 1'b0);
    check1("rst_done", done0, 1'b0);
    check1("rst_pass", pass0, 1'b0);
    check1("rst_timeout", to0, 1'b0);
    check1("rst_read", rd0, 1'b0);
    check1("rst_addr", ad0, 1'b0);
    check32("rst_id", id0, 32'd0);
    check32("rst_ts", ts0, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Zero-wait slave, default parameters.
    run(0, 0);
    check32("zw_done_cycle", first_done, 3);
    check32("zw_done_count", done_cnt, 1);
    check1("zw_rd1", rd_tr[1], 1'b1);
    check1("zw_ad1", ad_tr[1], 1'b0);
    check1("zw_rd2", rd_tr[2], 1'b1);
    check1("zw_ad2", ad_tr[2], 1'b1);
    check1("zw_rd3", rd_tr[3], 1'b0);
    check1("zw_busy3", busy_tr[3], 1'b1);
    check1("zw_busy4", busy_tr[4], 1'b0);
    check1("zw_pass", pass0, 1'b1);
    check1("zw_timeout", to0, 1'b0);
    check32("zw_id", id0, 32'd0);
    check32("zw_ts", ts0, TS_GOOD);

    // Wrong timestamp.
    ts_word0 = TS_BAD;
    run(0, 0);
    check32("badts_done_cycle", first_done, 3);
    check1("badts_pass", pass0, 1'b0);
    check1("badts_timeout", to0, 1'b0);
    check32("badts_ts", ts0, TS_BAD);
    ts_word0 = TS_GOOD;

    // Three stall cycles on each read: done in cycle 3 + 2*3.
    stall_n0 = 3;
    run(0, 0);
    check32("stall_done_cycle", first_done, 9);
    for (int n = 1; n <= 4; n++) begin
      check1("stall_rd_id", rd_tr[n], 1'b1);
      check1("stall_ad_id", ad_tr[n], 1'b0);
    end
    for (int n = 5; n <= 8; n++) begin
      check1("stall_rd_ts", rd_tr[n], 1'b1);
      check1("stall_ad_ts", ad_tr[n], 1'b1);
    end
    check1("stall_pass", pass0, 1'b1);

    // TIMEOUT=4, waitrequest stuck high.
    stall_n1 = 255;
    run(1, 0);
    check32("to_done_cycle", first_done, 5);
    check1("to_rd4", rd_tr[4], 1'b1);
    check1("to_rd5", rd_tr[5], 1'b0);
    check1("to_timeout", to1, 1'b1);
    check1("to_pass", pass1, 1'b0);
    check32("to_id", id1, 32'd0);
    check32("to_ts", ts1, 32'd0);

    // Acceptance on the last allowed cycle wins over the timeout.
    stall_n1 = 3;
    run(1, 0);
    check32("edge_done_cycle", first_done, 9);
    check1("edge_timeout", to1, 1'b0);
    check1("edge_pass", pass1, 1'b1);
    check32("edge_ts", ts1, TS_GOOD);

    // READ_LATENCY=2, with a second start while busy: done in cycle 3 + 2*2.
    run(2, 2);
    check32("lat_done_cycle", first_done, 7);
    check32("lat_done_count", done_cnt, 1);
    check1("lat_busy8", busy_tr[8], 1'b0);
    check1("lat_busy12", busy_tr[12], 1'b0);
    check1("lat_pass", pass2, 1'b1);
    check32("lat_id", id2, ID_LAT);
    check32("lat_ts", ts2, TS_GOOD);

    // Reset in the middle of the timestamp read.
    sel = 0;
    stall_n0 = 3;
    start0 = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      start0 = 1'b0;
    end
    check1("mid_rd", rd0, 1'b1);
    check1("mid_ad", ad0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check1("arst_busy", busy0, 1'b0);
    check1("arst_read", rd0, 1'b0);
    check1("arst_addr", ad0, 1'b0);
    check1("arst_pass", pass0, 1'b0);
    check1("arst_done", done0, 1'b0);
    check32("arst_id", id0, 32'd0);
    check32("arst_ts", ts0, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clock);
      check1("post_rst_done", done0, 1'b0);
      check1("post_rst_busy", busy0, 1'b0);
    end
    stall_n0 = 0;
    run(0, 0);
    check32("post_rst_done_cycle", first_done, 3);
    check1("post_rst_pass", pass0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
